axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, read data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting for slave handshake; 8-bit counter.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset, sampled on rising clk edge.
REQ-006 SHALL have ports m0_araddr/m0_arvalid (input, ADDR_W/1) and m0_arready (output, 1): IFU request AR channel.
REQ-007 SHALL have ports m0_rdata/m0_rresp/m0_rvalid (output, DATA_W/2/1) and m0_rready (input, 1): IFU response R channel.
REQ-008 SHALL have ports m1_* (same set, widths and directions as m0_*): LSU read channel.
REQ-009 SHALL have ports s_araddr/s_arvalid (output, ADDR_W/1) and s_arready (input, 1): shared memory AR channel.
REQ-010 SHALL have ports s_rdata/s_rresp/s_rvalid (input, DATA_W/2/1) and s_rready (output, 1): shared memory R channel.
REQ-011 SHALL have port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ADDR, DATA, RESP_ERR; one transaction in flight at a time.
REQ-013 In IDLE, SHALL drive all arready/rvalid/s_arvalid/s_rready low and register a grant on a cycle where any m*_arvalid is high, then move to ADDR.
REQ-014 Arbitration SHALL be round-robin: when both request, grant the master not granted last; a lone requester is always granted.
REQ-015 Grant SHALL stay locked from leaving IDLE until return to IDLE; the ungranted master sees arready=0 and rvalid=0 throughout.
REQ-016 In ADDR, s_araddr/s_arvalid SHALL combinationally equal the granted master's araddr/arvalid, and the granted master's arready SHALL equal s_arready; on s_arvalid&&s_arready move to DATA.
REQ-017 In DATA, granted master's rdata/rresp/rvalid SHALL equal s_rdata/s_rresp/s_rvalid and s_rready SHALL equal the granted master's rready; on s_rvalid&&s_rready move to IDLE.
REQ-018 Minimum latency SHALL be 1 cycle from master arvalid to s_arvalid; back-to-back transactions SHALL have exactly one IDLE cycle between them.
REQ-019 Watchdog counter SHALL clear on entering ADDR or DATA and increment each cycle spent in ADDR or DATA; at count==TIMEOUT without the pending handshake, move to RESP_ERR.
REQ-020 In RESP_ERR, SHALL drive granted master rvalid=1, rresp=2'b10, rdata=0, keep s_arvalid/s_rready low, and return to IDLE on granted rready.
REQ-021 Master arvalid dropping in ADDR before handshake SHALL be forwarded unchanged (no protocol repair); arbiter stays in ADDR until handshake or timeout.
REQ-022 When s_arready and s_rvalid are high on the same cycle in ADDR, only the AR handshake SHALL be taken; R is accepted in DATA.
REQ-023 The last-grant bit SHALL update only on the IDLE->ADDR transition.

Reset
REQ-024 On rising clk with rst==0: state=IDLE, last-grant=m1 (so m0/IFU wins first tie), watchdog=0.
REQ-025 During and after reset all outputs SHALL be 0 (s_araddr=0, rdata=0, rresp=0, busy_o=0).
REQ-026 Reset asserted mid-transaction SHALL abort it with no response delivered to either master.

Structure
REQ-027 State encodings, RRESP codes (OKAY 2'b00, SLVERR 2'b10), and the RST_ENABLE level SHALL live in the shared defines file.
REQ-028 SHALL contain one sub-module, rr_arb2, the combinational 2-way round-robin grant from the two requests and the last-grant bit; FSM, muxes and watchdog stay in the top.

Verification
REQ-029 m0 alone requests addr 0x8000_0000, slave arready +2 cycles, rvalid +3 with data 0xDEAD_BEEF -> m0 gets 0xDEAD_BEEF rresp 0, m1 sees no rvalid.
REQ-030 m0 and m1 request together after reset -> m0 granted first, m1 second; repeated tie -> grants alternate m0,m1,m0,m1.
REQ-031 m1 requests while m0 is in DATA -> m1 arready held 0 until m0 completes, s_arvalid for m1 rises after one IDLE cycle.
REQ-032 Slave never asserts arready, TIMEOUT=8 -> after 8 cycles in ADDR, m0 gets rvalid with rresp 2'b10 and rdata 0, busy_o falls after rready.
REQ-033 rst pulled low for one cycle during DATA -> next cycle state IDLE, all outputs 0, no rvalid to any master.
REQ-034 Granted master holds rready=0 for 4 cycles with s_rvalid=1 -> s_rready stays 0, data held, single handshake on the cycle rready rises.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter.
// Holds the FSM state encoding, the RRESP codes driven back to masters,
// the reset-active level and the watchdog counter width.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADDR     = 2'd1,
        ST_DATA     = 2'd2,
        ST_RESP_ERR = 2'd3
    } state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    // Level of rst that holds the design in reset (active-low).
    localparam logic RST_ENABLE = 1'b0;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_req0, i_req1 : request lines from master 0 / master 1
//   i_last         : master granted most recently (0 = m0, 1 = m1)
//   o_any          : at least one request present
//   o_gnt          : index of the master to grant (valid when o_any)
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_any,
    output logic o_gnt
);

    assign o_any = i_req0 | i_req1;

    // On a tie the master that did not win last time wins; a lone
    // requester always wins, which reduces to picking m1 iff it requests.
    assign o_gnt = (i_req0 & i_req1) ? ~i_last : i_req1;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates two AXI read masters (m0 = IFU, m1 = LSU) onto one shared
// memory read port, one transaction in flight at a time.
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   m0_ar*/m0_r*, m1_ar*/m1_r*    : master-side AR and R channels
//   s_ar*/s_r*                    : shared slave-side AR and R channels
//   busy_o                        : high whenever a transaction is open
// Grant is registered in IDLE and locked until the return to IDLE. A
// watchdog turns a stalled slave handshake into a SLVERR response.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic              busy_o
);

    localparam logic [WDOG_W-1:0] TIMEOUT_CNT = WDOG_W'(TIMEOUT);

    state_t              r_state;
    logic                r_grant;
    logic                r_last;
    logic [WDOG_W-1:0]   r_wdog;

    logic                w_run;
    logic                w_any;
    logic                w_gnt;
    logic [ADDR_W-1:0]   w_sel_araddr;
    logic                w_sel_arvalid;
    logic                w_sel_rready;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic [WDOG_W-1:0]   w_wdog_inc;
    logic                w_wdog_expired;

    rr_arb2 u_rr_arb2 (
        .i_req0 (m0_arvalid),
        .i_req1 (m1_arvalid),
        .i_last (r_last),
        .o_any  (w_any),
        .o_gnt  (w_gnt)
    );

    // Outputs are forced low while rst is held so nothing leaks during reset.
    assign w_run = (rst != RST_ENABLE);

    assign w_sel_araddr  = r_grant ? m1_araddr  : m0_araddr;
    assign w_sel_arvalid = r_grant ? m1_arvalid : m0_arvalid;
    assign w_sel_rready  = r_grant ? m1_rready  : m0_rready;

    assign w_ar_hs = w_sel_arvalid & s_arready;
    assign w_r_hs  = s_rvalid & w_sel_rready;

    // The watchdog counts cycles already spent in the waiting state; it
    // fires when the cycle now ending would bring that count to TIMEOUT.
    assign w_wdog_inc     = r_wdog + 1'b1;
    assign w_wdog_expired = (w_wdog_inc == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_gnt;
                        r_last  <= w_gnt;
                        r_wdog  <= '0;
                        r_state <= ST_ADDR;
                    end
                end
                // R is ignored here even if s_rvalid is already high.
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_wdog  <= '0;
                        r_state <= ST_DATA;
                    end else if (w_wdog_expired) begin
                        r_state <= ST_RESP_ERR;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_state <= ST_IDLE;
                    end else if (w_wdog_expired) begin
                        r_state <= ST_RESP_ERR;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                ST_RESP_ERR: begin
                    if (w_sel_rready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = RRESP_OKAY;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = RRESP_OKAY;
        m1_rvalid  = 1'b0;
        if (w_run) begin
            case (r_state)
                ST_ADDR: begin
                    s_araddr  = w_sel_araddr;
                    s_arvalid = w_sel_arvalid;
                    if (r_grant) m1_arready = s_arready;
                    else         m0_arready = s_arready;
                end
                ST_DATA: begin
                    s_rready = w_sel_rready;
                    if (r_grant) begin
                        m1_rdata  = s_rdata;
                        m1_rresp  = s_rresp;
                        m1_rvalid = s_rvalid;
                    end else begin
                        m0_rdata  = s_rdata;
                        m0_rresp  = s_rresp;
                        m0_rvalid = s_rvalid;
                    end
                end
                ST_RESP_ERR: begin
                    if (r_grant) begin
                        m1_rvalid = 1'b1;
                        m1_rresp  = RRESP_SLVERR;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rresp  = RRESP_SLVERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = w_run && (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic          m0_arvalid, m1_arvalid, s_arvalid;
    logic          m0_arready, m1_arready, s_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic          busy_o;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy_o(busy_o)
    );

    typedef struct {
        bit          m;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t       r_q[$];
    logic [31:0] ar_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          m0_hs_cnt = 0;

    // slave model controls and state
    bit          slave_en = 1'b0;
    bit          slave_mute = 1'b0;
    int          sl_ar_delay = 0;
    int          sl_r_delay = 0;
    int          sl_ar_wait = 0;
    int          sl_r_wait = 0;
    bit          sl_have = 1'b0;
    logic [31:0] sl_addr = '0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_r(input bit m, input logic [31:0] d, input logic [1:0] r);
        rexp_t e;
        e.m = m; e.data = d; e.resp = r;
        r_q.push_back(e);
    endtask

    task automatic slave_reset();
        sl_have = 1'b0; sl_ar_wait = 0; sl_r_wait = 0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    endtask

    // Master AR drop on handshake plus a simple slave with programmable delays.
    task automatic bfm();
        bit m0h, m1h, arh, rh;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            m0h = m0_arvalid && m0_arready;
            m1h = m1_arvalid && m1_arready;
            arh = s_arvalid && s_arready;
            rh  = s_rvalid && s_rready;
            a   = s_araddr;
            @(posedge clk);
            #1;
            if (m0h) m0_arvalid = 1'b0;
            if (m1h) m1_arvalid = 1'b0;
            if (slave_en) begin
                if (rh) begin
                    s_rvalid = 1'b0; s_rdata = '0; sl_have = 1'b0;
                end
                if (arh) begin
                    s_arready = 1'b0; sl_have = 1'b1; sl_addr = a;
                    sl_r_wait = sl_r_delay; sl_ar_wait = 0;
                end else if (s_arvalid && !sl_have && !slave_mute) begin
                    if (sl_ar_wait >= sl_ar_delay) s_arready = 1'b1;
                    else sl_ar_wait++;
                end
                if (sl_have && !s_rvalid) begin
                    if (sl_r_wait == 0) begin
                        s_rvalid = 1'b1; s_rdata = mem_model(sl_addr); s_rresp = 2'b00;
                    end else begin
                        sl_r_wait--;
                    end
                end
            end
        end
    endtask

    // Scoreboard: every R beat and every slave AR handshake is popped and compared.
    task automatic monitor();
        rexp_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic v;
                logic [31:0] d;
                logic [1:0] r;
                v = (m == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready);
                d = (m == 0) ? m0_rdata : m1_rdata;
                r = (m == 0) ? m0_rresp : m1_rresp;
                if (v) begin
                    if (m == 0) m0_hs_cnt++;
                    n_checks++;
                    if (r_q.size() == 0) begin
                        $display("FAIL r_beat_m%0d: got unexpected beat data %h resp %b, required none", m, d, r);
                    end else begin
                        e = r_q.pop_front();
                        if (e.m !== 1'(m) || d !== e.data || r !== e.resp)
                            $display("FAIL r_beat: got m%0d data %h resp %b, required m%0d data %h resp %b",
                                     m, d, r, e.m, e.data, e.resp);
                        else n_pass++;
                    end
                end
            end
            if (s_arvalid && s_arready) begin
                n_checks++;
                if (ar_q.size() == 0) begin
                    $display("FAIL ar_hs: got unexpected addr %h, required none", s_araddr);
                end else begin
                    ea = ar_q.pop_front();
                    if (s_araddr !== ea) $display("FAIL ar_hs: got addr %h, required %h", s_araddr, ea);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int g = 0; g < 200; g++) begin
            step();
            if (busy_o === 1'b0 && !m0_arvalid && !m1_arvalid && r_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!done) $display("FAIL %s_done: got busy=%b pending=%0d, required idle with no pending", name, busy_o, r_q.size());
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        slave_reset();
        step(); step();
        rst = 1'b1;
        r_q.delete(); ar_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h1234_5678;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11;
        step(); step();
        n_checks++;
        if ({busy_o, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 7'b0)
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {busy_o, s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid});
        else n_pass++;
        n_checks++;
        if (s_araddr !== 32'h0) $display("FAIL reset_araddr: got %h, required 0", s_araddr);
        else n_pass++;
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h %h, required 0", m0_rdata, m1_rdata);
        else n_pass++;
        n_checks++;
        if ({m0_rresp, m1_rresp} !== 4'h0) $display("FAIL reset_rresp: got %b %b, required 0", m0_rresp, m1_rresp);
        else n_pass++;
        m0_arvalid = 1'b0;
        slave_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_release_busy: got %b, required 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_single();
        slave_en = 1'b1; sl_ar_delay = 2; sl_r_delay = 3;
        ar_q.push_back(32'h8000_0000);
        exp_r(1'b0, 32'hDEAD_BEEF, 2'b00);
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || s_arvalid !== 1'b0)
            $display("FAIL single_idle: got busy=%b s_arvalid=%b, required 0 0", busy_o, s_arvalid);
        else n_pass++;
        step();
        n_checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || busy_o !== 1'b1)
            $display("FAIL single_latency: got s_arvalid=%b addr=%h busy=%b, required 1 80000000 1",
                     s_arvalid, s_araddr, busy_o);
        else n_pass++;
        n_checks++;
        if (m1_arready !== 1'b0 || m1_rvalid !== 1'b0)
            $display("FAIL single_m1_quiet: got arready=%b rvalid=%b, required 0 0", m1_arready, m1_rvalid);
        else n_pass++;
        wait_done("single");
    endtask

    task automatic test_tie();
        do_reset();
        sl_ar_delay = 0; sl_r_delay = 1;
        for (int rnd = 0; rnd < 2; rnd++) begin
            logic [31:0] a0, a1;
            a0 = 32'h1000_0000 + 32'(rnd * 16);
            a1 = 32'h2000_0000 + 32'(rnd * 16);
            ar_q.push_back(a0); ar_q.push_back(a1);
            exp_r(1'b0, mem_model(a0), 2'b00);
            exp_r(1'b1, mem_model(a1), 2'b00);
            m0_araddr = a0; m1_araddr = a1;
            m0_arvalid = 1'b1; m1_arvalid = 1'b1;
            wait_done("tie");
        end
    endtask

    task automatic test_hold_off();
        bit ok = 1'b1;
        int g = 0;
        sl_ar_delay = 0; sl_r_delay = 3;
        ar_q.push_back(32'h3000_0000); ar_q.push_back(32'h4000_0040);
        exp_r(1'b0, mem_model(32'h3000_0000), 2'b00);
        exp_r(1'b1, mem_model(32'h4000_0040), 2'b00);
        m0_araddr = 32'h3000_0000; m0_arvalid = 1'b1;
        while (m0_arvalid && g < 50) begin step(); g++; end
        m1_araddr = 32'h4000_0040; m1_arvalid = 1'b1;
        #1;
        g = 0;
        while (busy_o === 1'b1 && g < 50) begin
            if (m1_arready !== 1'b0 || m1_rvalid !== 1'b0) ok = 1'b0;
            step(); #1; g++;
        end
        n_checks++;
        if (!ok || g >= 50) $display("FAIL holdoff_m1_blocked: got ok=%b cycles=%0d, required ok=1 within 50", ok, g);
        else n_pass++;
        n_checks++;
        if (s_arvalid !== 1'b0 || m1_arready !== 1'b0)
            $display("FAIL holdoff_idle_gap: got s_arvalid=%b m1_arready=%b, required 0 0", s_arvalid, m1_arready);
        else n_pass++;
        step(); #1;
        n_checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 32'h4000_0040 || busy_o !== 1'b1)
            $display("FAIL holdoff_m1_ar: got s_arvalid=%b addr=%h busy=%b, required 1 40000040 1",
                     s_arvalid, s_araddr, busy_o);
        else n_pass++;
        wait_done("holdoff");
    endtask

    task automatic test_timeout();
        int cnt = 0;
        slave_reset();
        slave_mute = 1'b1;
        m0_rready = 1'b0;
        exp_r(1'b0, 32'h0, 2'b10);
        m0_araddr = 32'h5000_0000; m0_arvalid = 1'b1;
        for (int g = 0; g < 40; g++) begin
            step();
            if (m0_rvalid === 1'b1) break;
            if (s_arvalid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != TO) $display("FAIL timeout_addr_cycles: got %0d, required %0d", cnt, TO);
        else n_pass++;
        n_checks++;
        if (m0_rvalid !== 1'b1 || m0_rresp !== 2'b10 || m0_rdata !== 32'h0 || s_arvalid !== 1'b0 || s_rready !== 1'b0)
            $display("FAIL timeout_err_resp: got rvalid=%b rresp=%b rdata=%h s_arvalid=%b s_rready=%b, required 1 10 0 0 0",
                     m0_rvalid, m0_rresp, m0_rdata, s_arvalid, s_rready);
        else n_pass++;
        m0_arvalid = 1'b0;
        step();
        n_checks++;
        if (m0_rvalid !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL timeout_err_hold: got rvalid=%b busy=%b, required 1 1", m0_rvalid, busy_o);
        else n_pass++;
        m0_rready = 1'b1;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || m0_rvalid !== 1'b0)
            $display("FAIL timeout_release: got busy=%b rvalid=%b, required 0 0", busy_o, m0_rvalid);
        else n_pass++;
        slave_mute = 1'b0;
        slave_reset();
    endtask

    task automatic test_reset_mid();
        bit quiet = 1'b1;
        int g = 0;
        sl_ar_delay = 0; sl_r_delay = 3;
        ar_q.push_back(32'h6000_0000);
        m0_araddr = 32'h6000_0000; m0_arvalid = 1'b1;
        while (m0_arvalid && g < 50) begin step(); g++; end
        rst = 1'b0;
        #1;
        n_checks++;
        if (m0_rvalid !== 1'b0 || s_rready !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL rstmid_during: got rvalid=%b s_rready=%b busy=%b, required 0 0 0", m0_rvalid, s_rready, busy_o);
        else n_pass++;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || s_rready !== 1'b0 || s_arvalid !== 1'b0 || m0_rvalid !== 1'b0)
            $display("FAIL rstmid_after: got busy=%b s_rready=%b s_arvalid=%b rvalid=%b, required 0 0 0 0",
                     busy_o, s_rready, s_arvalid, m0_rvalid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL rstmid_no_resp: got a response after abort, required none");
        else n_pass++;
        slave_reset();
    endtask

    task automatic test_rready_stall();
        int g = 0;
        int hs0;
        logic [31:0] ed;
        sl_ar_delay = 0; sl_r_delay = 0;
        ed = mem_model(32'h7000_0000);
        m0_rready = 1'b0;
        ar_q.push_back(32'h7000_0000);
        exp_r(1'b0, ed, 2'b00);
        m0_araddr = 32'h7000_0000; m0_arvalid = 1'b1;
        while (m0_rvalid !== 1'b1 && g < 50) begin step(); g++; end
        hs0 = m0_hs_cnt;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (s_rready !== 1'b0 || m0_rvalid !== 1'b1 || m0_rdata !== ed)
                $display("FAIL stall_hold%0d: got s_rready=%b rvalid=%b rdata=%h, required 0 1 %h",
                         i, s_rready, m0_rvalid, m0_rdata, ed);
            else n_pass++;
            step();
        end
        m0_rready = 1'b1;
        #1;
        n_checks++;
        if (s_rready !== 1'b1) $display("FAIL stall_rready_pass: got %b, required 1", s_rready);
        else n_pass++;
        step();
        n_checks++;
        if (busy_o !== 1'b0 || m0_hs_cnt != hs0 + 1)
            $display("FAIL stall_single_hs: got busy=%b beats=%0d, required 0 1", busy_o, m0_hs_cnt - hs0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
        fork
            bfm();
            monitor();
        join_none
        test_reset();
        test_single();
        test_tie();
        test_hold_off();
        test_timeout();
        test_reset_mid();
        test_rready_stall();
        step();
        n_checks++;
        if (r_q.size() != 0 || ar_q.size() != 0)
            $display("FAIL scoreboard_drain: got r=%0d ar=%0d left, required 0 0", r_q.size(), ar_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
